riskow_wb_bridge: RTL
=====================

Name: riskow_wb_bridge

Overview:
Protocol bridge between the Riskow CPU native bus and the single Wishbone-classic master port of the processorci top level. Accepts one CPU request at a time (busValid/busReady handshake) and runs a registered Wishbone cycle. Feeds core_cyc/core_stb/core_we/core_sel/core_addr/core_data_out and consumes core_data_in/core_ack. Returns read data and busReady to the CPU.

Parameters:
ADDR_WIDTH, 32, width of the CPU and Wishbone address.
DATA_WIDTH, 32, width of the data buses; must be 32.
TIMEOUT_CYCLES, 1024, number of Wishbone wait cycles before abort; used only with the optional feature.
TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on an aborted transaction.

Ports:
sys_clk  in  1  core clock; all logic on the rising edge
rst_n  in  1  synchronous reset, active-low
cpu_address  in  ADDR_WIDTH  CPU request address
cpu_data_out  in  DATA_WIDTH  CPU write data
cpu_data_in  out  DATA_WIDTH  read data to the CPU
cpu_bus_valid  in  1  CPU request valid
cpu_bus_instr  in  1  request is an instruction fetch (status only)
cpu_bus_write_enable  in  1  1 = write, 0 = read
cpu_bus_ready  out  1  one-cycle completion pulse to the CPU
wb_cyc  out  1  Wishbone cycle
wb_stb  out  1  Wishbone strobe
wb_we  out  1  Wishbone write enable
wb_sel  out  4  byte selects
wb_addr  out  ADDR_WIDTH  Wishbone address
wb_data_out  out  DATA_WIDTH  Wishbone write data
wb_data_in  in  DATA_WIDTH  Wishbone read data
wb_ack  in  1  Wishbone acknowledge
busy  out  1  high while a transaction is outstanding
fetch_pending  out  1  latched cpu_bus_instr of the current transaction
timeout_flag  out  1  sticky abort indicator

Behaviour:
- Interface: one clock, sys_clk. Reset rst_n is synchronous and active-low.
- Reset values: wb_cyc, wb_stb, wb_we, cpu_bus_ready, busy, fetch_pending and timeout_flag are 0. wb_sel is 4'b0000. wb_addr, wb_data_out and cpu_data_in are 0. The state machine is IDLE.
- All outputs are registered.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - If cpu_bus_valid=1 at an edge, latch address, write data, write_enable and instr.
  - On that same edge, go to BUS and drive wb_cyc=wb_stb=1, wb_we=latched WE, wb_sel=4'b1111, busy=1.
  - If cpu_bus_valid=0, remain in IDLE.
  - wb_ack is ignored in IDLE.
- BUS:
  - Hold all Wishbone outputs stable until wb_ack=1 is sampled.
  - On the ack edge, drop wb_cyc/wb_stb/wb_we and set wb_sel=0. On a read, capture wb_data_in into cpu_data_in.
  - On the same edge, set cpu_bus_ready=1 and go to DONE.
  - Changes on the cpu_* inputs during BUS are ignored.
- DONE:
  - cpu_bus_ready is high for exactly this one cycle.
  - The next edge clears cpu_bus_ready and busy and returns to IDLE.
- Upstream rule: the CPU deasserts cpu_bus_valid or presents a new request in the cycle after the ready pulse. A valid sampled in IDLE is always treated as a new request.
- Latency: valid sampled at edge N puts stb high in cycle N+1. With ack in that same cycle, ready is high in cycle N+2. Minimum turnaround from one request to the next is 3 cycles.
- cpu_data_in holds the last completed read value. Writes leave it unchanged.
- wb_addr is the CPU address, forwarded unmodified. Only full-word accesses are issued.
- Reset asserted mid-transaction: at the reset edge, wb_cyc/wb_stb drop immediately, any pending ack is discarded and no ready pulse is issued.
- An ack arriving while rst_n=0 is ignored.

Optional Feature:
RISKOW_BRIDGE_TIMEOUT_EN
- Defined:
  - A wait counter clears on entry to BUS and increments each BUS cycle without an ack.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack, the bridge drops wb_cyc/wb_stb and sets cpu_data_in=TIMEOUT_DATA (reads only).
  - It then pulses cpu_bus_ready via DONE and sets timeout_flag=1, which stays high until reset.
  - An ack on the same edge as the timeout wins: normal completion, no flag.
- Not defined:
  - No counter is built and BUS waits indefinitely.
  - timeout_flag is tied 0.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> all outputs 0, busy=0.
- Read, zero-wait: valid, addr=0x100, WE=0; ack in first stb cycle with wb_data_in=0x12345678 -> stb high 1 cycle, ready at N+2, cpu_data_in=0x12345678, wb_sel=4'b1111.
- Write, 3 wait states: addr=0x200, data=0xCAFEF00D -> wb_we=1 and wb_data_out=0xCAFEF00D stable 4 cycles, ready at N+5, cpu_data_in unchanged.
- Back-to-back fetches: valid held high with a new address after each ready -> 2 transactions, fetch_pending=1 for both, no duplicate issue.
- Reset mid-BUS: assert rst_n=0 during the 2nd wait cycle, then ack -> no ready pulse, wb_cyc=0, FSM back in IDLE.
- Timeout (macro on, TIMEOUT_CYCLES=8): read with no ack -> stb drops after 8 BUS cycles, cpu_data_in=0xDEADBEEF, ready pulse, timeout_flag=1 sticky.

Source files
------------

// File: rtl/riskow_wb_bridge_if.sv
// riskow_wb_bridge_if: signal bundle between the Riskow CPU native bus, the
// bridge and the Wishbone-classic slave side. The bridge uses the master view;
// the surrounding CPU/Wishbone environment uses the slave view.
interface riskow_wb_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] cpu_address;
    logic [DATA_WIDTH-1:0] cpu_data_out;
    logic [DATA_WIDTH-1:0] cpu_data_in;
    logic                  cpu_bus_valid;
    logic                  cpu_bus_instr;
    logic                  cpu_bus_write_enable;
    logic                  cpu_bus_ready;

    logic                  wb_cyc;
    logic                  wb_stb;
    logic                  wb_we;
    logic [3:0]            wb_sel;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data_out;
    logic [DATA_WIDTH-1:0] wb_data_in;
    logic                  wb_ack;

    modport master (
        input  cpu_address, cpu_data_out, cpu_bus_valid, cpu_bus_instr,
               cpu_bus_write_enable,
        output cpu_data_in, cpu_bus_ready,
        output wb_cyc, wb_stb, wb_we, wb_sel, wb_addr, wb_data_out,
        input  wb_data_in, wb_ack
    );

    modport slave (
        output cpu_address, cpu_data_out, cpu_bus_valid, cpu_bus_instr,
               cpu_bus_write_enable,
        input  cpu_data_in, cpu_bus_ready,
        input  wb_cyc, wb_stb, wb_we, wb_sel, wb_addr, wb_data_out,
        output wb_data_in, wb_ack
    );
endinterface

// File: rtl/riskow_wb_bridge.sv
// riskow_wb_bridge: Riskow CPU native bus to Wishbone-classic master bridge.
// One request at a time, every output registered.
// Optional wait-state abort: define RISKOW_BRIDGE_TIMEOUT_EN to build the
// wait counter and the sticky timeout_flag; otherwise BUS waits forever.
module riskow_wb_bridge #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    riskow_wb_bridge_if.master bus,
    output logic               busy,
    output logic               fetch_pending,
    output logic               timeout_flag
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t                r_state;
    logic                  r_wb_cyc;
    logic                  r_wb_stb;
    logic                  r_wb_we;
    logic                  r_write;
    logic [3:0]            r_wb_sel;
    logic [ADDR_WIDTH-1:0] r_wb_addr;
    logic [DATA_WIDTH-1:0] r_wb_data_out;
    logic [DATA_WIDTH-1:0] r_cpu_data_in;
    logic                  r_cpu_bus_ready;
    logic                  r_busy;
    logic                  r_fetch_pending;
    logic                  w_expire;

    // Only 32-bit data is supported and the abort counter needs at least two states
    if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 2) begin : g_bad_config
        $error("riskow_wb_bridge: unsupported parameter set");
    end

    // Request/Wishbone sequencer: latch in IDLE, hold in BUS until ack (or abort), pulse ready in DONE
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_wb_cyc        <= 1'b0;
            r_wb_stb        <= 1'b0;
            r_wb_we         <= 1'b0;
            r_write         <= 1'b0;
            r_wb_sel        <= 4'b0000;
            r_wb_addr       <= '0;
            r_wb_data_out   <= '0;
            r_cpu_data_in   <= '0;
            r_cpu_bus_ready <= 1'b0;
            r_busy          <= 1'b0;
            r_fetch_pending <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cpu_bus_valid) begin
                        r_wb_addr       <= bus.cpu_address;
                        r_wb_data_out   <= bus.cpu_data_out;
                        r_wb_we         <= bus.cpu_bus_write_enable;
                        r_write         <= bus.cpu_bus_write_enable;
                        r_fetch_pending <= bus.cpu_bus_instr;
                        r_wb_cyc        <= 1'b1;
                        r_wb_stb        <= 1'b1;
                        r_wb_sel        <= 4'b1111;
                        r_busy          <= 1'b1;
                        r_state         <= BUS;
                    end
                end
                BUS: begin
                    if (bus.wb_ack || w_expire) begin
                        r_wb_cyc        <= 1'b0;
                        r_wb_stb        <= 1'b0;
                        r_wb_we         <= 1'b0;
                        r_wb_sel        <= 4'b0000;
                        r_cpu_bus_ready <= 1'b1;
                        r_state         <= DONE;
                        if (!r_write) begin
                            r_cpu_data_in <= bus.wb_ack ? bus.wb_data_in : TIMEOUT_DATA;
                        end
                    end
                end
                DONE: begin
                    r_cpu_bus_ready <= 1'b0;
                    r_busy          <= 1'b0;
                    r_fetch_pending <= 1'b0;
                    r_state         <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef RISKOW_BRIDGE_TIMEOUT_EN
    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout_flag;

    // An ack on the final wait cycle still wins over the abort
    assign w_expire = !bus.wb_ack && (r_wait_cnt == WAIT_LAST);

    // Count unacknowledged BUS cycles and remember any abort until reset
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_wait_cnt     <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            if (r_state == BUS && !bus.wb_ack) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (r_state == BUS && w_expire) begin
                r_timeout_flag <= 1'b1;
            end
        end
    end

    assign timeout_flag = r_timeout_flag;
`else
    assign w_expire     = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    assign bus.wb_cyc        = r_wb_cyc;
    assign bus.wb_stb        = r_wb_stb;
    assign bus.wb_we         = r_wb_we;
    assign bus.wb_sel        = r_wb_sel;
    assign bus.wb_addr       = r_wb_addr;
    assign bus.wb_data_out   = r_wb_data_out;
    assign bus.cpu_data_in   = r_cpu_data_in;
    assign bus.cpu_bus_ready = r_cpu_bus_ready;
    assign busy              = r_busy;
    assign fetch_pending     = r_fetch_pending;

endmodule
